// File: rtl/tnn_pkg.sv
// tnn_pkg: shared FSM state type and elaboration-time sizing helpers for the TNN neuron.
package tnn_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    function automatic int clog2(input int v);
        int r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int acc_w(input int n_in, input int in_w);
        return clog2(n_in * ((1 << in_w) - 1) + 1);
    endfunction

    // A zero lane count is rejected by the top; avoid a divide-by-zero before that check fires.
    function automatic int beats(input int n_in, input int lanes);
        return lanes < 1 ? 1 : ceil_div(n_in, lanes);
    endfunction
endpackage

// File: rtl/tnn_lane_adder.sv
// tnn_lane_adder: combinational per-beat partial sums of the positive and negative lane groups.
module tnn_lane_adder #(
    parameter int LANES = 3,
    parameter int IN_W  = 2,
    parameter int ACC_W = 5
) (
    input  logic [LANES*IN_W-1:0] i_data,
    input  logic [LANES-1:0]      i_mask,
    input  logic [LANES-1:0]      i_valid,
    output logic [ACC_W-1:0]      o_pos,
    output logic [ACC_W-1:0]      o_neg
);
    logic [ACC_W-1:0] w_x;

    always_comb begin
        o_pos = '0;
        o_neg = '0;
        w_x   = '0;
        for (int l = 0; l < LANES; l++) begin
            w_x   = i_valid[l] ? ACC_W'(i_data[l*IN_W +: IN_W]) : '0;
            o_pos = o_pos + (i_mask[l] ? w_x : '0);
            o_neg = o_neg + (i_mask[l] ? '0 : w_x);
        end
    end
endmodule

// File: rtl/tnn_neuron_seq.sv
// tnn_neuron_seq: multi-cycle ternary threshold neuron accumulating LANES inputs per beat
// between a valid/ready input vector and a valid/ready registered result.
module tnn_neuron_seq
    import tnn_pkg::*;
#(
    parameter int          N_IN     = 9,
    parameter int          IN_W     = 2,
    parameter int          LANES    = 3,
    parameter logic [63:0] POS_MASK = 64'h188,
    parameter int          THRESH   = 1,
    localparam int         ACC_W    = acc_w(N_IN, IN_W)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_IN*IN_W-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_fire,
    output logic [ACC_W-1:0]     out_pos_sum,
    output logic [ACC_W-1:0]     out_neg_sum
);
    localparam int BEATS = beats(N_IN, LANES);
    localparam int CNT_W = BEATS > 1 ? clog2(BEATS) : 1;
    localparam int PAD   = BEATS * LANES;
    localparam int VW    = PAD * IN_W;
    localparam logic [PAD-1:0] MASK_PAD = PAD'(POS_MASK[N_IN-1:0]);

    if (LANES < 1 || LANES > N_IN || N_IN > 64 || (POS_MASK >> N_IN) != 64'd0) begin : g_bad_cfg
        $error("tnn_neuron_seq: LANES out of range or POS_MASK wider than N_IN");
    end

    state_t                r_state;
    logic [N_IN*IN_W-1:0]  r_vec;
    logic [ACC_W-1:0]      r_pos, r_neg;
    logic [CNT_W-1:0]      r_beat;
    logic [VW-1:0]         w_vec_pad;
    logic [LANES*IN_W-1:0] w_lane_data;
    logic [LANES-1:0]      w_lane_mask, w_lane_vld;
    logic [ACC_W-1:0]      w_lane_pos, w_lane_neg, w_pos, w_neg;
    logic signed [ACC_W+1:0] w_diff;
    logic                  w_in_ready, w_accept, w_last;

    assign w_vec_pad = VW'(r_vec);

    // Lanes past N_IN on the last beat are masked off so a partial beat adds nothing.
    always_comb begin
        w_lane_data = '0;
        w_lane_mask = '0;
        w_lane_vld  = '0;
        for (int b = 0; b < BEATS; b++)
            if (r_beat == CNT_W'(b)) begin
                w_lane_data = w_vec_pad[b*LANES*IN_W +: LANES*IN_W];
                w_lane_mask = MASK_PAD[b*LANES +: LANES];
                for (int l = 0; l < LANES; l++) w_lane_vld[l] = b * LANES + l < N_IN;
            end
    end

    tnn_lane_adder #(.LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W)) u_lane_adder (
        .i_data (w_lane_data),
        .i_mask (w_lane_mask),
        .i_valid(w_lane_vld),
        .o_pos  (w_lane_pos),
        .o_neg  (w_lane_neg)
    );

    assign w_pos      = r_pos + w_lane_pos;
    assign w_neg      = r_neg + w_lane_neg;
    assign w_diff     = $signed({2'b00, w_pos}) - $signed({2'b00, w_neg});
    assign w_last     = r_beat == CNT_W'(BEATS - 1);
    assign w_in_ready = r_state == IDLE || (r_state == DONE && out_ready);
    assign w_accept   = in_valid && w_in_ready;
    assign in_ready   = w_in_ready && !rst;
    assign out_valid  = r_state == DONE && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_vec       <= '0;
            r_pos       <= '0;
            r_neg       <= '0;
            r_beat      <= '0;
            out_fire    <= 1'b0;
            out_pos_sum <= '0;
            out_neg_sum <= '0;
        end else if (w_accept) begin
            r_state <= ACCUM;
            r_vec   <= in_data;
            r_pos   <= '0;
            r_neg   <= '0;
            r_beat  <= '0;
        end else if (r_state == ACCUM) begin
            r_pos  <= w_pos;
            r_neg  <= w_neg;
            r_beat <= r_beat + 1'b1;
            if (w_last) begin
                r_state     <= DONE;
                out_pos_sum <= w_pos;
                out_neg_sum <= w_neg;
                out_fire    <= int'(w_diff) >= THRESH;
            end
        end else if (r_state == DONE && out_ready) begin
            r_state <= IDLE;
        end
    end
endmodule

// File: tb/tb_tnn_neuron_seq.sv
// tb_tnn_neuron_seq: directed vectors against default, THRESH=0 and 10-input/4-lane neurons.
module tb_tnn_neuron_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] in_data;
    logic        in_valid, out_ready;
    logic        in_ready, out_valid, out_fire;
    logic [4:0]  out_pos_sum, out_neg_sum;
    logic        t0_in_ready, t0_out_valid, t0_out_fire;
    logic [4:0]  t0_pos_sum, t0_neg_sum;
    logic [19:0] wd_data;
    logic        wd_valid, wd_out_ready;
    logic        wd_in_ready, wd_out_valid, wd_fire;
    logic [4:0]  wd_pos_sum, wd_neg_sum;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    tnn_neuron_seq dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_fire(out_fire),
        .out_pos_sum(out_pos_sum), .out_neg_sum(out_neg_sum)
    );

    tnn_neuron_seq #(.THRESH(0)) dut_t0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(t0_in_ready),
        .out_valid(t0_out_valid), .out_ready(out_ready), .out_fire(t0_out_fire),
        .out_pos_sum(t0_pos_sum), .out_neg_sum(t0_neg_sum)
    );

    tnn_neuron_seq #(.N_IN(10), .LANES(4), .POS_MASK(64'h3FF)) dut_wide (
        .clk(clk), .rst(rst), .in_data(wd_data), .in_valid(wd_valid), .in_ready(wd_in_ready),
        .out_valid(wd_out_valid), .out_ready(wd_out_ready), .out_fire(wd_fire),
        .out_pos_sum(wd_pos_sum), .out_neg_sum(wd_neg_sum)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic wait_valid(input string tag);
        int lat = 0;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, 3);
    endtask

    // Offer one vector with out_ready=1, scramble in_data during ACCUM, then check the result.
    task automatic run_vec(input string tag, input logic [17:0] d, input int ep, input int en,
                           input logic ef, input logic ef0);
        in_data = d;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data = ~d;
        wait_valid(tag);
        chk({tag, "_pos"}, out_pos_sum, ep);
        chk({tag, "_neg"}, out_neg_sum, en);
        chk({tag, "_fire"}, out_fire, ef);
        chk({tag, "_fire_t0"}, t0_out_fire, ef0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        in_data = '0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        wd_data = '0;
        wd_valid = 1'b0;
        wd_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_fire", out_fire, 0);
        chk("rst_pos", out_pos_sum, 0);
        chk("rst_neg", out_neg_sum, 0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", in_ready, 1);
        @(negedge clk);

        run_vec("dhi", 18'h3C0C0, 9, 0, 1'b1, 1'b1);
        run_vec("all3", 18'h3FFFF, 9, 18, 1'b0, 1'b0);
        run_vec("zero", 18'h00000, 0, 0, 1'b0, 1'b1);
        run_vec("tie", 18'h000C3, 3, 3, 1'b0, 1'b1);

        // Backpressure: hold the result for 5 cycles, then accept the next vector on release.
        in_data = 18'h3FFFF;
        in_valid = 1'b1;
        out_ready = 1'b0;
        #1;
        chk("bp_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data = 18'h0;
        wait_valid("bp");
        for (int c = 0; c < 5; c++) begin
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_in_ready", in_ready, 0);
            chk("bp_hold_pos", out_pos_sum, 9);
            chk("bp_hold_neg", out_neg_sum, 18);
            @(negedge clk);
        end
        run_vec("b2b", 18'h3C0C0, 9, 0, 1'b1, 1'b1);

        // Reset during the second ACCUM cycle abandons the vector.
        in_data = 18'h3FFFF;
        in_valid = 1'b1;
        #1;
        chk("rstmid_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstmid_in_ready_rst", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstmid_in_ready_after", in_ready, 1);
        for (int c = 0; c < 5; c++) begin
            chk("rstmid_no_valid", out_valid, 0);
            @(negedge clk);
        end
        run_vec("post_rst", 18'h3C0C0, 9, 0, 1'b1, 1'b1);

        // Ten inputs in beats of four: partial last beat.
        wd_data = 20'hFFFFF;
        wd_valid = 1'b1;
        #1;
        chk("wide_in_ready", wd_in_ready, 1);
        @(negedge clk);
        wd_valid = 1'b0;
        wd_data = '0;
        begin
            int lat = 0;
            while (!wd_out_valid && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            chk("wide_latency", lat, 3);
        end
        chk("wide_pos", wd_pos_sum, 30);
        chk("wide_neg", wd_neg_sum, 0);
        chk("wide_fire", wd_fire, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
